// File: rtl/e203_ifu_bht_bpu.sv
// IFU branch predictor: 2-bit saturating-counter BHT for conditional branches, JAL/JALR operand
// generation with x1/xn dependency stall. Optional return-address stack under E203_BPU_RAS_EN.
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module e203_ifu_bht_bpu #(
    parameter int BHT_DEPTH = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [`E203_PC_SIZE-1:0]     pc,
    input  logic                         dec_i_valid,
    input  logic                         dec_i_hsked,
    input  logic                         dec_jal,
    input  logic                         dec_jalr,
    input  logic                         dec_bxx,
    input  logic                         dec_rv32,
    input  logic [`E203_XLEN-1:0]        dec_bjp_imm,
    input  logic [`E203_RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
    input  logic [`E203_RFIDX_WIDTH-1:0] dec_rdidx,
    input  logic                         oitf_empty,
    input  logic                         ir_empty,
    input  logic                         ir_rs1en,
    input  logic                         ir_valid_clr,
    input  logic                         jalr_rs1idx_cam_irrdidx,
    input  logic [`E203_XLEN-1:0]        rf2bpu_x1,
    input  logic [`E203_XLEN-1:0]        rf2bpu_rs1,
    input  logic                         upd_valid,
    input  logic [`E203_PC_SIZE-1:0]     upd_pc,
    input  logic                         upd_taken,
    input  logic                         ras_flush,
    output logic                         bpu_wait,
    output logic                         prdt_taken,
    output logic [`E203_PC_SIZE-1:0]     prdt_pc_add_op1,
    output logic [`E203_PC_SIZE-1:0]     prdt_pc_add_op2,
    output logic                         bpu2rf_rs1_ena
);
    localparam int IW = $clog2(BHT_DEPTH);
    localparam int PW = `E203_PC_SIZE;

    logic [IW-1:0] rd_idx, upd_idx;
    logic [1:0]    bht_r [BHT_DEPTH];

    assign rd_idx  = pc[IW+1:2];
    assign upd_idx = upd_pc[IW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_r[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht_r[upd_idx] != 2'b11)
                bht_r[upd_idx] <= bht_r[upd_idx] + 2'b01;
            else if (!upd_taken && bht_r[upd_idx] != 2'b00)
                bht_r[upd_idx] <= bht_r[upd_idx] - 2'b01;
        end
    end

    assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & bht_r[rd_idx][1]);

    logic rs1_x0, rs1_x1, rs1_xn;
    assign rs1_x0 = (dec_jalr_rs1idx == `E203_RFIDX_WIDTH'(0));
    assign rs1_x1 = (dec_jalr_rs1idx == `E203_RFIDX_WIDTH'(1));
    assign rs1_xn = ~rs1_x0 & ~rs1_x1;

    logic          ras_ret;
    logic [PW-1:0] ras_top;

`ifdef E203_BPU_RAS_EN
    localparam int PTRW = $clog2(RAS_DEPTH);

    logic [PW-1:0]   ras_mem [RAS_DEPTH];
    logic [PTRW-1:0] ras_ptr, ras_top_ptr;
    logic [PTRW:0]   ras_cnt;
    logic            ras_nempty, rd_x0, rd_x1, ras_push, ras_pop;
    logic [PW-1:0]   ret_addr;

    // ras_ptr is the next free slot; the top sits one below it (circular)
    assign ras_top_ptr = ras_ptr - PTRW'(1);
    assign ras_top     = ras_mem[ras_top_ptr];
    assign ras_nempty  = (ras_cnt != '0);
    assign rd_x0       = (dec_rdidx == `E203_RFIDX_WIDTH'(0));
    assign rd_x1       = (dec_rdidx == `E203_RFIDX_WIDTH'(1));
    assign ras_ret     = dec_jalr & rs1_x1 & rd_x0 & ras_nempty;
    assign ras_push    = dec_i_hsked & (dec_jal | dec_jalr) & rd_x1;
    assign ras_pop     = dec_i_hsked & dec_jalr & rs1_x1 & (rd_x0 | rd_x1) & ras_nempty;
    assign ret_addr    = pc + (dec_rv32 ? PW'(4) : PW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_flush) begin
            ras_cnt <= '0;
        end else if (ras_push && !ras_pop) begin
            ras_ptr <= ras_ptr + PTRW'(1);
            if (ras_cnt != (PTRW+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (PTRW+1)'(1);
        end else if (ras_pop && !ras_push) begin
            ras_ptr <= ras_top_ptr;
            ras_cnt <= ras_cnt - (PTRW+1)'(1);
        end
    end

    // Pop-then-push replaces the top in place
    always_ff @(posedge clk) begin
        if (!ras_flush && ras_push)
            ras_mem[ras_pop ? ras_top_ptr : ras_ptr] <= ret_addr;
    end
`else
    logic unused_ras;
    assign ras_ret    = 1'b0;
    assign ras_top    = '0;
    assign unused_ras = ^{dec_rdidx, dec_i_hsked, dec_rv32, ras_flush, 32'(RAS_DEPTH)};
`endif

    logic unused_upd;
    assign unused_upd = ^upd_pc;

    logic x1_wait, xn_dep, xn_release, rdrf_set, rdrf_r;
    assign x1_wait    = dec_i_valid & dec_jalr & rs1_x1 & ~ras_ret
                      & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
    assign xn_dep     = dec_i_valid & dec_jalr & rs1_xn & (~oitf_empty | ~ir_empty);
    assign xn_release = xn_dep & oitf_empty & ~ir_empty & (ir_valid_clr | ~ir_rs1en);
    assign rdrf_set   = ~rdrf_r & dec_i_valid & dec_jalr & rs1_xn & (~xn_dep | xn_release);

    // HELD lasts exactly one cycle, so the next state is simply the set term
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdrf_r <= 1'b0;
        else        rdrf_r <= rdrf_set;
    end

    assign bpu2rf_rs1_ena = rdrf_set;
    assign bpu_wait       = x1_wait | xn_dep | rdrf_set;

    always_comb begin
        prdt_pc_add_op1 = rf2bpu_rs1[PW-1:0];
        prdt_pc_add_op2 = dec_bjp_imm[PW-1:0];
        if (dec_bxx | dec_jal) begin
            prdt_pc_add_op1 = pc;
        end else if (ras_ret) begin
            prdt_pc_add_op1 = ras_top;
            prdt_pc_add_op2 = '0;
        end else if (rs1_x0) begin
            prdt_pc_add_op1 = '0;
        end else if (rs1_x1) begin
            prdt_pc_add_op1 = rf2bpu_x1[PW-1:0];
        end
    end
endmodule

// File: tb/tb_e203_ifu_bht_bpu.sv
// Directed self-checking bench for e203_ifu_bht_bpu (BHT, jalr dependency, RAS when compiled in).
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module tb_e203_ifu_bht_bpu;
    localparam int BHT_DEPTH = 64;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc, dec_bjp_imm, rf2bpu_x1, rf2bpu_rs1, upd_pc;
    logic        dec_i_valid, dec_i_hsked, dec_jal, dec_jalr, dec_bxx, dec_rv32;
    logic [4:0]  dec_jalr_rs1idx, dec_rdidx;
    logic        oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx;
    logic        upd_valid, upd_taken, ras_flush;
    logic        bpu_wait, prdt_taken, bpu2rf_rs1_ena;
    logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;
    int          n_cmp = 0, n_bad = 0;

    e203_ifu_bht_bpu #(.BHT_DEPTH(BHT_DEPTH), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .dec_i_valid(dec_i_valid), .dec_i_hsked(dec_i_hsked),
        .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_rv32(dec_rv32),
        .dec_bjp_imm(dec_bjp_imm), .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_rdidx(dec_rdidx),
        .oitf_empty(oitf_empty), .ir_empty(ir_empty), .ir_rs1en(ir_rs1en),
        .ir_valid_clr(ir_valid_clr), .jalr_rs1idx_cam_irrdidx(jalr_rs1idx_cam_irrdidx),
        .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .ras_flush(ras_flush), .bpu_wait(bpu_wait),
        .prdt_taken(prdt_taken), .prdt_pc_add_op1(prdt_pc_add_op1),
        .prdt_pc_add_op2(prdt_pc_add_op2), .bpu2rf_rs1_ena(bpu2rf_rs1_ena)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        pc = 32'h0; dec_bjp_imm = 32'h0; rf2bpu_x1 = 32'hAAAA_0000; rf2bpu_rs1 = 32'h1234_5678;
        upd_pc = 32'h0; dec_i_valid = 0; dec_i_hsked = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
        dec_rv32 = 1; dec_jalr_rs1idx = 0; dec_rdidx = 0; oitf_empty = 1; ir_empty = 1;
        ir_rs1en = 0; ir_valid_clr = 0; jalr_rs1idx_cam_irrdidx = 0; upd_valid = 0;
        upd_taken = 0; ras_flush = 0;
    endtask

    task automatic bht_update(input logic [31:0] p, input logic t);
        upd_pc = p; upd_taken = t; upd_valid = 1; tick(); upd_valid = 0;
    endtask

    task automatic test_reset();
        idle(); rst_n = 0; #1;
        n_cmp++; if ({bpu_wait, prdt_taken, bpu2rf_rs1_ena} !== 3'b000) begin n_bad++;
            $display("FAIL reset_outs: got %b want 000", {bpu_wait, prdt_taken, bpu2rf_rs1_ena}); end
        tick(); rst_n = 1; tick();
        n_cmp++; if (dut.rdrf_r !== 1'b0) begin n_bad++; $display("FAIL reset_rdrf: got %b want 0", dut.rdrf_r); end
    endtask

    task automatic test_bht_train();
        idle(); dec_i_valid = 1; dec_bxx = 1; pc = 32'h8000_0010; dec_bjp_imm = 32'hFFFF_FFF8; #1;
        n_cmp++; if (prdt_taken !== 1'b0) begin n_bad++; $display("FAIL train_init: got %b want 0", prdt_taken); end
        n_cmp++; if (prdt_pc_add_op1 !== 32'h8000_0010) begin n_bad++; $display("FAIL train_op1: got %h want 80000010", prdt_pc_add_op1); end
        n_cmp++; if (prdt_pc_add_op2 !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL train_op2: got %h want fffffff8", prdt_pc_add_op2); end
        bht_update(32'h8000_0010, 1);
        bht_update(32'h8000_0010, 1); #1;
        n_cmp++; if (prdt_taken !== 1'b1) begin n_bad++; $display("FAIL train_taken: got %b want 1", prdt_taken); end
    endtask

    task automatic test_bht_sat_alias();
        // counter at 11 from training
        bht_update(32'h8000_0010, 0);
        n_cmp++; if (prdt_taken !== 1'b1) begin n_bad++; $display("FAIL sat_nt1: got %b want 1", prdt_taken); end
        bht_update(32'h8000_0010, 0);
        n_cmp++; if (prdt_taken !== 1'b0) begin n_bad++; $display("FAIL sat_nt2: got %b want 0", prdt_taken); end
        bht_update(32'h8000_0010, 0);
        bht_update(32'h8000_0010, 0);
        n_cmp++; if (dut.bht_r[4] !== 2'b00) begin n_bad++; $display("FAIL sat_floor: got %b want 00", dut.bht_r[4]); end
        bht_update(32'h8000_0010, 1);
        n_cmp++; if (prdt_taken !== 1'b0) begin n_bad++; $display("FAIL sat_t1: got %b want 0", prdt_taken); end
        // train through an aliasing PC, observe at the original
        bht_update(32'h8000_0010 + BHT_DEPTH*4, 1);
        n_cmp++; if (prdt_taken !== 1'b1) begin n_bad++; $display("FAIL alias_upd: got %b want 1", prdt_taken); end
        pc = 32'h8000_0010 + BHT_DEPTH*4; #1;
        n_cmp++; if (prdt_taken !== 1'b1) begin n_bad++; $display("FAIL alias_rd: got %b want 1", prdt_taken); end
        pc = 32'h8000_0014; #1;
        n_cmp++; if (prdt_taken !== 1'b0) begin n_bad++; $display("FAIL other_idx: got %b want 0", prdt_taken); end
    endtask

    task automatic test_same_cycle();
        // mid-operation reset returns index 4 (currently 10) to 01 at once
        pc = 32'h8000_0010; rst_n = 0; #1;
        n_cmp++; if (prdt_taken !== 1'b0) begin n_bad++; $display("FAIL reset_mid: got %b want 0", prdt_taken); end
        tick(); rst_n = 1; tick();
        upd_pc = 32'h8000_0010; upd_taken = 1; upd_valid = 1; #1;
        n_cmp++; if (prdt_taken !== 1'b0) begin n_bad++; $display("FAIL same_cyc_old: got %b want 0", prdt_taken); end
        tick(); upd_valid = 0; #1;
        n_cmp++; if (prdt_taken !== 1'b1) begin n_bad++; $display("FAIL same_cyc_new: got %b want 1", prdt_taken); end
    endtask

    task automatic test_xn_jalr();
        idle(); dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 5; dec_bjp_imm = 32'h10; #1;
        n_cmp++; if ({bpu_wait, bpu2rf_rs1_ena} !== 2'b11) begin n_bad++; $display("FAIL xn_c0: got %b want 11", {bpu_wait, bpu2rf_rs1_ena}); end
        tick();
        n_cmp++; if ({bpu_wait, bpu2rf_rs1_ena} !== 2'b00) begin n_bad++; $display("FAIL xn_c1: got %b want 00", {bpu_wait, bpu2rf_rs1_ena}); end
        n_cmp++; if (prdt_pc_add_op1 !== 32'h1234_5678) begin n_bad++; $display("FAIL xn_op1: got %h want 12345678", prdt_pc_add_op1); end
        n_cmp++; if (prdt_taken !== 1'b1) begin n_bad++; $display("FAIL xn_taken: got %b want 1", prdt_taken); end
        dec_i_valid = 0; tick();
        // outstanding OITF entry blocks the read
        dec_i_valid = 1; oitf_empty = 0; #1;
        n_cmp++; if ({bpu_wait, bpu2rf_rs1_ena} !== 2'b10) begin n_bad++; $display("FAIL xn_dep: got %b want 10", {bpu_wait, bpu2rf_rs1_ena}); end
        oitf_empty = 1; ir_empty = 0; ir_rs1en = 1; #1;
        n_cmp++; if ({bpu_wait, bpu2rf_rs1_ena} !== 2'b10) begin n_bad++; $display("FAIL xn_ir_dep: got %b want 10", {bpu_wait, bpu2rf_rs1_ena}); end
        ir_valid_clr = 1; #1;
        n_cmp++; if ({bpu_wait, bpu2rf_rs1_ena} !== 2'b11) begin n_bad++; $display("FAIL xn_release: got %b want 11", {bpu_wait, bpu2rf_rs1_ena}); end
        idle(); tick();
    endtask

    task automatic test_x1_dep();
        idle(); dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 1; oitf_empty = 0; #1;
        n_cmp++; if (bpu_wait !== 1'b1) begin n_bad++; $display("FAIL x1_wait0: got %b want 1", bpu_wait); end
        tick();
        n_cmp++; if (bpu_wait !== 1'b1) begin n_bad++; $display("FAIL x1_wait1: got %b want 1", bpu_wait); end
        oitf_empty = 1; #1;
        n_cmp++; if ({bpu_wait, bpu2rf_rs1_ena} !== 2'b00) begin n_bad++; $display("FAIL x1_go: got %b want 00", {bpu_wait, bpu2rf_rs1_ena}); end
        n_cmp++; if (prdt_pc_add_op1 !== 32'hAAAA_0000) begin n_bad++; $display("FAIL x1_op1: got %h want aaaa0000", prdt_pc_add_op1); end
        jalr_rs1idx_cam_irrdidx = 1; #1;
        n_cmp++; if (bpu_wait !== 1'b1) begin n_bad++; $display("FAIL x1_cam: got %b want 1", bpu_wait); end
        idle(); dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 0; dec_bjp_imm = 32'h40; oitf_empty = 0; #1;
        n_cmp++; if ({bpu_wait, prdt_pc_add_op1, prdt_pc_add_op2} !== {1'b0, 32'h0, 32'h40}) begin n_bad++;
            $display("FAIL x0_jalr: got %b %h %h want 0 0 40", bpu_wait, prdt_pc_add_op1, prdt_pc_add_op2); end
        idle(); dec_i_valid = 1; pc = 32'h300; #1;
        n_cmp++; if (prdt_taken !== 1'b0) begin n_bad++; $display("FAIL non_branch: got %b want 0", prdt_taken); end
        dec_jal = 1; dec_bjp_imm = 32'h20; #1;
        n_cmp++; if ({prdt_taken, prdt_pc_add_op1} !== {1'b1, 32'h300}) begin n_bad++; $display("FAIL jal: got %b %h want 1 300", prdt_taken, prdt_pc_add_op1); end
        idle();
    endtask

    task automatic call(input logic [31:0] p, input logic rv32);
        idle(); dec_i_valid = 1; dec_i_hsked = 1; dec_jal = 1; dec_rdidx = 1; pc = p; dec_rv32 = rv32;
        tick(); idle();
    endtask

`ifdef E203_BPU_RAS_EN
    task automatic test_ras();
        logic [31:0] exp [5];
        call(32'h100, 1);
        dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 1; dec_rdidx = 0; oitf_empty = 0; #1;
        n_cmp++; if ({bpu_wait, prdt_pc_add_op1, prdt_pc_add_op2} !== {1'b0, 32'h104, 32'h0}) begin n_bad++;
            $display("FAIL ras_ret: got %b %h %h want 0 104 0", bpu_wait, prdt_pc_add_op1, prdt_pc_add_op2); end
        dec_i_hsked = 1; tick(); idle();
        call(32'h200, 1); call(32'h300, 1); call(32'h400, 1); call(32'h500, 1); call(32'h600, 0);
        exp[0] = 32'h602; exp[1] = 32'h504; exp[2] = 32'h404; exp[3] = 32'h304; exp[4] = 32'hAAAA_0000;
        for (int i = 0; i < 5; i++) begin
            dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 1; dec_rdidx = 0; oitf_empty = 0; #1;
            n_cmp++; if ({bpu_wait, prdt_pc_add_op1} !== {(i == 4), exp[i]}) begin n_bad++;
                $display("FAIL ras_lifo%0d: got %b %h want %b %h", i, bpu_wait, prdt_pc_add_op1, (i == 4), exp[i]); end
            dec_i_hsked = 1; tick(); idle();
        end
        call(32'h700, 1);
        ras_flush = 1; tick(); idle();
        dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 1; oitf_empty = 0; #1;
        n_cmp++; if ({bpu_wait, prdt_pc_add_op1} !== {1'b1, 32'hAAAA_0000}) begin n_bad++;
            $display("FAIL ras_flush: got %b %h want 1 aaaa0000", bpu_wait, prdt_pc_add_op1); end
        idle();
    endtask
`else
    task automatic test_no_ras();
        call(32'h100, 1);
        dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 1; dec_rdidx = 0; oitf_empty = 0; dec_bjp_imm = 32'h8; #1;
        n_cmp++; if ({bpu_wait, prdt_pc_add_op1, prdt_pc_add_op2} !== {1'b1, 32'hAAAA_0000, 32'h8}) begin n_bad++;
            $display("FAIL ret_x1: got %b %h %h want 1 aaaa0000 8", bpu_wait, prdt_pc_add_op1, prdt_pc_add_op2); end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_bht_train();
        test_bht_sat_alias();
        test_same_cycle();
        test_xn_jalr();
        test_x1_dep();
`ifdef E203_BPU_RAS_EN
        test_ras();
`else
        test_no_ras();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/e203_ifu_bht_bpu.md
# e203_ifu_bht_bpu

Parametrised successor to the IFU simple branch predictor, sitting in the IFU mini-decode stage beside the PC generator. Conditional branches are predicted with a direct-mapped table of 2-bit saturating counters that the EXU updates when branches resolve. JAL/JALR target operands are produced exactly as before, including the x1/xn RAW-dependency stall and the regfile read-port borrow. An optional return-address stack (RAS) predicts function returns without waiting on x1.

## Interface
Parameters:
- BHT_DEPTH, 64, number of counter entries; power of two, ≥4; index width IW = log2(BHT_DEPTH)
- RAS_DEPTH, 4, RAS entries; power of two, ≥2; used only when the RAS is compiled in

Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pc  in  `E203_PC_SIZE  PC of the decoded instruction
- dec_i_valid  in  1  decoded instruction valid
- dec_i_hsked  in  1  one-cycle pulse when the decoded instruction is accepted by the IFU
- dec_jal, dec_jalr, dec_bxx  in  1 each  instruction class
- dec_rv32  in  1  1 = 32-bit instruction, 0 = compressed
- dec_bjp_imm  in  `E203_XLEN  branch/jump immediate
- dec_jalr_rs1idx, dec_rdidx  in  `E203_RFIDX_WIDTH  rs1 and rd indices
- oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx  in  1 each  EXU/IR dependency status
- rf2bpu_x1, rf2bpu_rs1  in  `E203_XLEN  x1 hardwire and regfile read-port-1 data
- upd_valid  in  1  EXU resolved a conditional branch
- upd_pc  in  `E203_PC_SIZE  PC of the resolved branch
- upd_taken  in  1  actual outcome of the resolved branch
- ras_flush  in  1  pipeline flush; empties the RAS
- bpu_wait  out  1  stall next-PC generation
- prdt_taken  out  1  predicted taken
- prdt_pc_add_op1, prdt_pc_add_op2  out  `E203_PC_SIZE  target adder operands
- bpu2rf_rs1_ena  out  1  borrow regfile read port 1 for rs1

## Operation
- BHT index = pc[IW+1:2]; the update index is upd_pc[IW+1:2]. Aliasing is permitted.
- Counter reset value is 2'b01 (weakly not-taken).
- Prediction:
  - bxx: prdt_taken = counter[1].
  - jal and jalr: prdt_taken = 1.
  - All other instructions: prdt_taken = 0.
- Update on upd_valid:
  - upd_taken = 1: the counter increments, saturating at 11.
  - upd_taken = 0: the counter decrements, saturating at 00.
- Dependency logic:
  - rs1 = x0: no dependency.
  - rs1 = x1: wait while dec_i_valid & jalr & (~oitf_empty | jalr_rs1idx_cam_irrdidx).
  - rs1 = xn: wait while dec_i_valid & jalr & (~oitf_empty | ~ir_empty). The IR dependency is released when oitf_empty & ~ir_empty & (ir_valid_clr | ~ir_rs1en).
- Read-port FSM, 1-bit rdrf_r with states IDLE and HELD:
  - IDLE→HELD on set = ~rdrf_r & dec_i_valid & jalr & rs1=xn & (no xn dependency | dependency released).
  - HELD→IDLE unconditionally on the next cycle.
  - bpu2rf_rs1_ena = set.
  - bpu_wait = x1 wait | xn wait | set.
- op1 selection:
  - bxx or jal: pc.
  - jalr rs1=x0: 0.
  - jalr rs1=x1: rf2bpu_x1.
  - Otherwise: rf2bpu_rs1.
- op2 = dec_bjp_imm[`E203_PC_SIZE-1:0].
- Width rule: the upper XLEN bits are truncated to PC_SIZE.

## Timing
- Prediction outputs are combinational from the decode inputs and the current counter state. There is no registered latency.
- A BHT update is written at the clk edge and is visible from the next cycle. A same-cycle lookup of the same index sees the old value; there is no bypass.
- An xn jalr with no dependency behaves as follows:
  - Cycle 0: bpu_wait = 1 and bpu2rf_rs1_ena = 1.
  - Cycle 1: rdrf_r = 1, bpu_wait = 0, and op1 = rf2bpu_rs1.
- RAS push and pop occur only on dec_i_hsked, so a stalled instruction never pushes twice.
- Reset values:
  - rdrf_r = 0 and the RAS is empty.
  - With idle inputs, bpu_wait, prdt_taken and bpu2rf_rs1_ena are all 0.
- A reset mid-operation discards all counters and RAS state immediately.

## Configuration
Macro: E203_BPU_RAS_EN.

When E203_BPU_RAS_EN is defined:
- Call = (jal | jalr) & rd=x1. On dec_i_hsked, push pc+4 if dec_rv32, else pc+2.
- Return = jalr & rs1=x1 & rd=x0 & RAS non-empty:
  - op1 = RAS top and op2 = 0.
  - No x1 dependency wait applies.
  - Pop on dec_i_hsked.
- jalr with rd=x1 and rs1=x1: pop then push. The count is unchanged and the top is replaced.
- Push on full overwrites the oldest entry (circular buffer); the count saturates at RAS_DEPTH.
- A return on an empty RAS falls back to the x1 path.
- ras_flush empties the RAS next cycle and takes priority over a same-cycle push or pop.

When E203_BPU_RAS_EN is not defined:
- No RAS storage is built.
- Returns are handled as ordinary rs1=x1 jalr.

## Test plan
- BHT training: after reset, bxx at pc 0x80000010 with imm −8 → prdt_taken = 0, op1 = 0x80000010, op2 = 0xFFFFFFF8. After two upd_taken = 1 updates → prdt_taken = 1.
- BHT saturation and aliasing: from state 11, four not-taken updates → counter 00, with the fourth holding at 00. pc 0x80000010 + BHT_DEPTH·4 reads the same counter.
- Same-cycle update and lookup: upd_valid to index 4 while a bxx looks up index 4 at state 01 → prdt_taken = 0 this cycle, 1 next cycle after a taken update.
- xn jalr: jalr x5 with oitf_empty = 1 and ir_empty = 1 → cycle 0 bpu_wait = 1 and ena = 1; cycle 1 bpu_wait = 0 and op1 = rf2bpu_rs1.
- x1 dependency: jalr x1 with oitf_empty = 0 → bpu_wait stays 1 until oitf_empty rises, then 0 in the same cycle.
- RAS (macro on, RAS_DEPTH = 4):
  - jal x1 at 0x100 (32-bit), then ret → op1 = 0x104, op2 = 0, and bpu_wait = 0 with oitf_empty = 0.
  - Five calls followed by five returns → the first four returns are predicted from the RAS in LIFO order; the fifth uses rf2bpu_x1.
